// File: rtl/multicycle_ctrlr.sv
// multicycle_ctrlr: FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port; WND_OVERFLOW_TRAP_EN traps CWND in the last window.
// 2-5 cycles per instruction; FETCH and MEM stall while mem_req is high and mem_ready is low.
module multicycle_ctrlr #(
  parameter int NUM_WND = 4,
  parameter int WP_W    = $clog2(NUM_WND)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      opcode,
  input  logic [7:0]      func,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            ir_load,
  output logic            pc_write,
  output logic [1:0]      PCSel,
  output logic [1:0]      ALUSel,
  output logic [2:0]      ALUOP,
  output logic            dataSel,
  output logic            regWriteEn,
  output logic            memWriteEn,
  output logic            changeWnd,
  output logic [WP_W-1:0] wnd_ptr,
  output logic            illegal
);

  typedef enum logic [2:0] {
    st_fetch, st_decode, st_exec, st_mem, st_wb, st_halted, st_trap
  } state_t;

  localparam logic [3:0] op_rtype = 4'd0;
  localparam logic [3:0] op_addi  = 4'd1;
  localparam logic [3:0] op_load  = 4'd2;
  localparam logic [3:0] op_store = 4'd3;
  localparam logic [3:0] op_beqz  = 4'd4;
  localparam logic [3:0] op_jump  = 4'd5;
  localparam logic [3:0] op_cwnd  = 4'd6;
  localparam logic [3:0] op_halt  = 4'd7;

  state_t          state, next_state;
  logic [WP_W-1:0] wnd_q;
  logic            wnd_inc;
  logic            func_onehot;
  logic            op_illegal;
  logic            wnd_top;
  logic [2:0]      func_idx;
  logic [2:0]      alu_op;
  logic [1:0]      alu_sel;

  assign func_onehot = (func != 8'd0) && ((func & (func - 8'd1)) == 8'd0);
  assign op_illegal  = opcode[3] || ((opcode == op_rtype) && !func_onehot);
  assign wnd_top     = (wnd_q == WP_W'(NUM_WND - 1));
  assign wnd_ptr     = rst ? '0 : wnd_q;

  always_comb begin
    func_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (func[i]) func_idx = 3'(i);
    end
  end

  // Shared by EXEC and MEM so the address stays stable across the memory wait.
  always_comb begin
    alu_op  = 3'd0;
    alu_sel = 2'b00;
    case (opcode)
      op_rtype:                  alu_op  = func_idx;
      op_addi, op_load, op_store: alu_sel = 2'b01;
      op_beqz:                   alu_op  = 3'd1;
      default: ;
    endcase
  end

  always_comb begin
    next_state = state;
    wnd_inc    = 1'b0;
    mem_req    = 1'b0;
    ir_load    = 1'b0;
    pc_write   = 1'b0;
    PCSel      = 2'b00;
    ALUSel     = 2'b00;
    ALUOP      = 3'd0;
    dataSel    = 1'b0;
    regWriteEn = 1'b0;
    memWriteEn = 1'b0;
    changeWnd  = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      case (state)
        st_fetch: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_load    = 1'b1;
            pc_write   = 1'b1;
            next_state = st_decode;
          end
        end
        st_decode: begin
          if (op_illegal) begin
            next_state = st_trap;
          end else begin
            case (opcode)
              op_halt: next_state = st_halted;
              op_jump: begin
                pc_write   = 1'b1;
                PCSel      = 2'b10;
                next_state = st_fetch;
              end
              op_cwnd: begin
`ifdef WND_OVERFLOW_TRAP_EN
                if (wnd_top) begin
                  next_state = st_trap;
                end else begin
                  changeWnd  = 1'b1;
                  wnd_inc    = 1'b1;
                  next_state = st_fetch;
                end
`else
                changeWnd  = 1'b1;
                wnd_inc    = 1'b1;
                next_state = st_fetch;
`endif
              end
              default: next_state = st_exec;
            endcase
          end
        end
        st_exec: begin
          ALUOP  = alu_op;
          ALUSel = alu_sel;
          case (opcode)
            op_rtype, op_addi: next_state = st_wb;
            op_load, op_store: next_state = st_mem;
            op_beqz: begin
              pc_write   = zero;
              PCSel      = 2'b01;
              next_state = st_fetch;
            end
            default: next_state = st_fetch;
          endcase
        end
        st_mem: begin
          mem_req    = 1'b1;
          ALUOP      = alu_op;
          ALUSel     = alu_sel;
          memWriteEn = (opcode == op_store);
          if (mem_ready) next_state = (opcode == op_store) ? st_fetch : st_wb;
        end
        st_wb: begin
          regWriteEn = 1'b1;
          dataSel    = (opcode == op_load);
          next_state = st_fetch;
        end
        st_halted: ;
        st_trap:   illegal = 1'b1;
        default:   next_state = st_fetch;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= st_fetch;
      wnd_q <= '0;
    end else begin
      state <= next_state;
      if (wnd_inc) wnd_q <= wnd_top ? '0 : wnd_q + WP_W'(1);
    end
  end

endmodule
